// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Byte handshake between a producer (CPU-side UART register) and the UART
// transmitter FIFO.
//   tx_data  : byte to send, sampled when tx_valid && tx_ready
//   tx_valid : producer has a byte
//   tx_ready : transmitter FIFO can accept a byte
// Modports: master = producer, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with a small byte FIFO. Bytes accepted on the valid/ready
// handshake are queued and sent on `tx` as 8N1 frames (start, 8 data bits LSB
// first, stop), or 8E1 when UART_TX_PARITY_EN is defined (even parity bit
// inserted after data bit 7). Bit timing comes from an internal counter.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (2..8191)
//   FIFO_DEPTH   : FIFO entries, power of two, >= 2
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   bus        : slave side of uart_tx_fifo_if (tx_data / tx_valid / tx_ready)
//   tx         : registered serial line, idle high
//   tx_busy    : frame in progress (FSM not idle)
//   fifo_count : bytes queued, not counting the byte being shifted
// Optional feature macro: UART_TX_PARITY_EN
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_if.slave               bus,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full         = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty        = (count_q == '0);
  // Ready follows the registered count only, so a same-cycle pop never
  // opens a slot combinationally.
  assign bus.tx_ready = !full;
  assign push         = bus.tx_valid && bus.tx_ready;
  assign fifo_count   = count_q;

  // NOTE: storage has no reset; only pointers and count define validity, which
  // keeps the array as plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q;
  logic             tx_q, tx_d;
  logic             load;
  logic             bit_end;
  logic [2:0]       next_idx;

  assign bit_end  = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign next_idx = bit_idx_q + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      if (load) shift_q <= mem[rd_ptr];
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
        tx_d      = 1'b1;
        if (!empty) begin
          state_d = START;
          pop     = 1'b1;
          load    = 1'b1;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^shift_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = next_idx;
            tx_d      = shift_q[next_idx];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          // Chain straight into the next frame when a byte is waiting.
          if (!empty) begin
            state_d = START;
            pop     = 1'b1;
            load    = 1'b1;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        bit_idx_d = '0;
        tx_d      = 1'b1;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter: the transmit-side counterpart of the baud-timed UART receive path. It accepts bytes over a valid/ready handshake into a small FIFO and serialises them on the `tx` line as 8N1 frames (start bit, 8 data bits LSB first, stop bit), or 8E1 when parity is compiled in. Bit timing comes from an internal bit counter; no external baud pulse is used. It sits between the CPU's memory-mapped UART register and the board TX pin.

## Interface
- `CLKS_PER_BIT`, 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..8191.
- `FIFO_DEPTH`, 4, byte FIFO entries; must be a power of two, at least 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset: one clock, asynchronous, active-high; clears everything immediately on assertion.
- `tx_data`  in  8  byte to send; sampled when `tx_valid && tx_ready`.
- `tx_valid`  in  1  producer has a byte.
- `tx_ready`  out  1  FIFO not full; reset value 1.
- `tx`  out  1  serial line, registered, idle high; reset value 1.
- `tx_busy`  out  1  FSM not in IDLE; reset value 0.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted; reset value 0.

## Operation
- FIFO:
  - A push occurs on any edge with `tx_valid && tx_ready`.
  - `tx_ready` = !full. It is derived from the count only; a pop in the same cycle does not raise it.
  - A push and a pop on the same edge leave `fifo_count` unchanged.
  - Data written while full is ignored and the count does not change.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- Bit counter:
  - `bit_cnt` counts 0..CLKS_PER_BIT-1 and clears on every state change.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - `bit_idx` (0..7) selects the data bit.
- IDLE → START when the FIFO is non-empty. On that edge: pop the head into the shift register, set `tx`=0, clear the counters.
- START → DATA when `bit_cnt`==CLKS_PER_BIT-1; `tx`=data[0].
- DATA:
  - At the end of each bit: `bit_idx`++ and `tx`=data[bit_idx].
  - After bit 7 (`bit_idx`==7 at end of bit): go to PARITY if enabled, otherwise STOP.
- PARITY → STOP at the end of the parity bit; `tx`=1.
- STOP at the end of the stop bit:
  - FIFO non-empty: pop, go straight to START, `tx`=0 (no idle gap between frames).
  - FIFO empty: go to IDLE, `tx` stays 1.
- Reset mid-frame:
  - `tx` goes to 1 asynchronously; the FSM goes to IDLE and the FIFO empties.
  - The partial frame is abandoned and is not resent.

## Timing
- Latency: a push at edge N into an empty FIFO with the FSM in IDLE makes `tx` fall after edge N+1; `fifo_count` reads 1 for exactly one cycle.
- Frame length is exactly 10×CLKS_PER_BIT cycles (11× with parity), from the falling edge of the start bit to the end of the stop bit.
- Back-to-back frames are exactly one frame length apart.
- `tx_busy` rises after the edge that enters START. It falls after the edge that enters IDLE.
- The first cycle after reset deasserts may accept a push.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is inserted between data bit 7 and the stop bit.
  - The bit value is even parity, the XOR of data[7:0].
  - Frame = 11 bits.
- Not defined:
  - No PARITY state and no parity logic; frame = 10 bits.
  - DATA goes directly to STOP.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Single byte: push 0xA5 → `tx` low 4 cycles, then 1,0,1,0,0,1,0,1 (LSB first) at 4 cycles each, then high. `tx_busy` is high 40 cycles (44 with parity).
- Back-to-back: push 0x00, 0xFF, 0x3C on consecutive cycles → three contiguous frames with no idle cycle between them. `fifo_count` sequence after the pushes: 1, 1, 2, then decrements at each frame start.
- Full: while the first frame is shifting, push 5 bytes without a pop → `tx_ready`=0 once count=4. The 5th byte is dropped; only 4 further frames appear.
- Parity (macro defined): 0x55 → parity bit 0; 0x07 → parity bit 1. Without the macro, the stop bit follows data bit 7 directly.
- Reset mid-frame: assert `rst` during data bit 3 of 0x81 with 2 bytes queued → `tx`=1 and `tx_busy`=0 immediately, `fifo_count`=0. After release, no frame starts until a new push.
- Simultaneous push/pop: push on the same edge the STOP→START pop occurs → `fifo_count` unchanged, and the byte order is preserved.
